// File: rtl/wb_arb_pkg.sv
// Shared types, default widths and helpers for the round-robin Wishbone interconnect.
// The widths match the L1-cache / DRAM line bus.
package wb_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int WB_DEFAULT_NUM_MASTERS = 2;
    localparam int WB_DEFAULT_ADDR_W      = 12;
    localparam int WB_DEFAULT_DATA_W      = 128;
    localparam int WB_DEFAULT_SEL_W       = WB_DEFAULT_DATA_W / 8;
    localparam int WB_DEFAULT_TIMEOUT     = 256;

    // Width of an owner index; never zero, even for two masters.
    function automatic int owner_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // (base + off) mod n, for base < n and off < n.
    function automatic int wrap_add(input int base, input int off, input int n);
        int sum;
        sum = base + off;
        return (sum >= n) ? sum - n : sum;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: first active request at or after i_ptr,
// wrapping from N-1 back to 0. Works for any N >= 2, not only powers of two.
module wb_rr_picker
    import wb_arb_pkg::*;
#(
    parameter int N     = WB_DEFAULT_NUM_MASTERS,
    parameter int IDX_W = owner_idx_w(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // NOTE: every output gets a default before the search loop, so no latch is inferred.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!o_valid && i_req[wrap_add(int'(i_ptr), k, N)]) begin
                o_valid                             = 1'b1;
                o_gnt[wrap_add(int'(i_ptr), k, N)] = 1'b1;
                o_idx                               = IDX_W'(wrap_add(int'(i_ptr), k, N));
            end
        end
    end

endmodule

// File: rtl/wb_rr_interconnect.sv
// N-master to 1-slave Wishbone interconnect with round-robin arbitration; a grant is
// held for one whole transfer. Optional watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_rr_interconnect
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = WB_DEFAULT_NUM_MASTERS,
    parameter int ADDR_W         = WB_DEFAULT_ADDR_W,
    parameter int DATA_W         = WB_DEFAULT_DATA_W,
    parameter int SEL_W          = WB_DEFAULT_SEL_W,
    parameter int TIMEOUT_CYCLES = WB_DEFAULT_TIMEOUT
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_MASTERS-1:0]             m_cyc,
    input  logic [NUM_MASTERS-1:0]             m_stb,
    input  logic [NUM_MASTERS-1:0]             m_we,
    input  logic [NUM_MASTERS-1:0][ADDR_W-1:0] m_adr,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0] m_dat_w,
    input  logic [NUM_MASTERS-1:0][SEL_W-1:0]  m_sel,
    output logic [DATA_W-1:0]                  m_dat_r,
    output logic [NUM_MASTERS-1:0]             m_ack,
    output logic [NUM_MASTERS-1:0]             m_rty,
    output logic [NUM_MASTERS-1:0]             m_err,
    output logic                               s_cyc,
    output logic                               s_stb,
    output logic                               s_we,
    output logic [ADDR_W-1:0]                  s_adr,
    output logic [DATA_W-1:0]                  s_dat_w,
    output logic [SEL_W-1:0]                   s_sel,
    input  logic [DATA_W-1:0]                  s_dat_r,
    input  logic                               s_ack,
    input  logic                               s_rty,
    output logic [NUM_MASTERS-1:0]             grant
);

    localparam int IDX_W = owner_idx_w(NUM_MASTERS);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;
    logic [IDX_W-1:0]       r_owner;
    logic [IDX_W-1:0]       r_rr_ptr;
    logic [NUM_MASTERS-1:0] r_gnt;

    logic [NUM_MASTERS-1:0] w_req;
    logic [NUM_MASTERS-1:0] w_pick_gnt;
    logic [IDX_W-1:0]       w_pick_idx;
    logic                   w_pick_valid;
    logic [IDX_W-1:0]       w_ptr_nxt;
    logic                   w_busy;
    logic                   w_owner_cyc;
    logic                   w_resp;
    logic                   w_expire;
    logic                   w_release;

    assign w_req = m_cyc & m_stb;

    wb_rr_picker #(
        .N     (NUM_MASTERS),
        .IDX_W (IDX_W)
    ) u_picker (
        .i_req   (w_req),
        .i_ptr   (r_rr_ptr),
        .o_gnt   (w_pick_gnt),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    assign w_busy      = (r_state == ARB_BUSY);
    assign w_owner_cyc = w_busy & m_cyc[r_owner];
    assign w_resp      = w_owner_cyc & (s_ack | s_rty);
    assign w_ptr_nxt   = (r_owner == IDX_W'(NUM_MASTERS - 1)) ? '0 : r_owner + 1'b1;
    assign m_dat_r     = s_dat_r;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] r_wd_cnt;

    // A slave response in the expiry cycle takes priority over the watchdog.
    assign w_expire = w_owner_cyc & ~(s_ack | s_rty)
                    & (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n)
            r_wd_cnt <= '0;
        else if (!w_busy)
            r_wd_cnt <= '0;
        else if (!w_resp)
            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
`else
    assign w_expire = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_release   = 1'b0;
        unique case (r_state)
            ARB_IDLE: if (w_pick_valid) w_state_nxt = ARB_BUSY;
            ARB_BUSY: begin
                // Completion, abort (owner dropped CYC) and watchdog expiry all free the bus.
                if (!w_owner_cyc || w_resp || w_expire) begin
                    w_state_nxt = ARB_IDLE;
                    w_release   = 1'b1;
                end
            end
            default: w_state_nxt = ARB_IDLE;
        endcase
    end

    // Responses are masked while rst_n is low so a reset wins over a same-cycle ACK.
    always_comb begin
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        m_ack   = '0;
        m_rty   = '0;
        m_err   = '0;
        grant   = '0;
        if (w_busy) begin
            s_cyc          = w_owner_cyc;
            s_stb          = m_stb[r_owner];
            s_we           = m_we[r_owner];
            s_adr          = m_adr[r_owner];
            s_dat_w        = m_dat_w[r_owner];
            s_sel          = m_sel[r_owner];
            grant          = r_gnt;
            m_ack[r_owner] = s_ack & w_owner_cyc & rst_n;
            m_rty[r_owner] = s_rty & w_owner_cyc & rst_n;
            m_err[r_owner] = w_expire & rst_n;
        end
    end

    // NOTE: state registers use non-blocking assignments and a reset sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ARB_IDLE;
            r_owner  <= '0;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (!w_busy && w_pick_valid) begin
                r_owner <= w_pick_idx;
                r_gnt   <= w_pick_gnt;
            end
            if (w_release)
                r_rr_ptr <= w_ptr_nxt;
        end
    end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// Scoreboard bench for wb_rr_interconnect (3 masters): directed transfers with expected
// responses and grant order queued up front, checked by independent monitors.
module tb_wb_rr_interconnect;

    localparam int N  = 3;
    localparam int AW = 12;
    localparam int DW = 128;
    localparam int SW = 16;

    typedef enum int {K_ACK, K_RTY, K_ERR} kind_t;

    typedef struct {
        int          master;
        kind_t       kind;
        logic [AW-1:0] adr;
        logic        we;
        logic [DW-1:0] dat;
        logic [SW-1:0] sel;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] m_cyc = '0, m_stb = '0, m_we = '0;
    logic [N-1:0][AW-1:0] m_adr = '0;
    logic [N-1:0][DW-1:0] m_dat_w = '0;
    logic [N-1:0][SW-1:0] m_sel = '0;
    logic [DW-1:0] m_dat_r;
    logic [N-1:0] m_ack, m_rty, m_err, grant;
    logic s_cyc, s_stb, s_we;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat_w;
    logic [SW-1:0] s_sel;
    logic [DW-1:0] s_dat_r = '0;
    logic s_ack = 1'b0, s_rty = 1'b0;

    logic slave_auto = 1'b1;
    logic slave_rty = 1'b0;
    logic slave_silent = 1'b0;
    int   slave_lat = 1;

    exp_t exp_q[$];
    int   gnt_q[$];
    int   n_checks = 0;
    int   n_fails = 0;

    wb_rr_interconnect #(
        .NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .SEL_W(SW), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr),
        .m_dat_w(m_dat_w), .m_sel(m_sel), .m_dat_r(m_dat_r),
        .m_ack(m_ack), .m_rty(m_rty), .m_err(m_err),
        .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr),
        .s_dat_w(s_dat_w), .s_sel(s_sel), .s_dat_r(s_dat_r),
        .s_ack(s_ack), .s_rty(s_rty), .grant(grant)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] txn_dat(input int m, input logic [AW-1:0] adr);
        return {4{4'(m), 16'h5A00, adr}};
    endfunction

    function automatic logic [SW-1:0] txn_sel(input int m, input logic [AW-1:0] adr);
        return {adr[3:0], 4'(m), 8'hFF};
    endfunction

    function automatic logic [DW-1:0] slave_rdata(input logic [AW-1:0] adr);
        return {8{4'hC, adr}};
    endfunction

    function automatic logic [N-1:0] oh(input int m);
        return N'(1) << m;
    endfunction

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int m, input kind_t k, input logic [AW-1:0] adr);
        exp_t e;
        e.master = m;
        e.kind   = k;
        e.adr    = adr;
        e.we     = adr[0];
        e.dat    = txn_dat(m, adr);
        e.sel    = txn_sel(m, adr);
        exp_q.push_back(e);
    endtask

    task automatic set_req(input int m, input logic [AW-1:0] adr);
        m_cyc[m]   = 1'b1;
        m_stb[m]   = 1'b1;
        m_we[m]    = adr[0];
        m_adr[m]   = adr;
        m_dat_w[m] = txn_dat(m, adr);
        m_sel[m]   = txn_sel(m, adr);
    endtask

    task automatic clr_req(input int m);
        m_cyc[m]   = 1'b0;
        m_stb[m]   = 1'b0;
        m_we[m]    = 1'b0;
        m_adr[m]   = '0;
        m_dat_w[m] = '0;
        m_sel[m]   = '0;
    endtask

    task automatic run_master(input int m, input int n, input logic [AW-1:0] base);
        int c;
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            set_req(m, base + AW'(k));
            c = 0;
            do begin
                @(negedge clk);
                c++;
            end while (!(m_ack[m] | m_rty[m] | m_err[m]) && c < 60);
            check($sformatf("resp_seen_m%0d", m), c < 60, 1);
        end
        @(posedge clk); #1;
        clr_req(m);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) clr_req(i);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic drain(input string tag);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || gnt_q.size() != 0) && c < 100) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_resp_left"}, exp_q.size(), 0);
        check({tag, "_gnt_left"}, gnt_q.size(), 0);
    endtask

    // Slave model: responds slave_lat cycles after it first sees STB.
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge clk); #2;
            if (slave_auto) begin
                s_dat_r = slave_rdata(s_adr);
                if (s_cyc && s_stb && !slave_silent) begin
                    if (cnt == slave_lat) begin
                        s_ack = !slave_rty;
                        s_rty = slave_rty;
                        cnt   = 0;
                    end else begin
                        s_ack = 1'b0;
                        s_rty = 1'b0;
                        cnt++;
                    end
                end else begin
                    s_ack = 1'b0;
                    s_rty = 1'b0;
                    cnt   = 0;
                end
            end
        end
    end

    // Response monitor: every master-side response must match the head of exp_q.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if ((m_ack | m_rty | m_err) != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", {m_err, m_rty, m_ack}, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_ack", m_ack, (e.kind == K_ACK) ? oh(e.master) : '0);
                    check("resp_rty", m_rty, (e.kind == K_RTY) ? oh(e.master) : '0);
                    check("resp_err", m_err, (e.kind == K_ERR) ? oh(e.master) : '0);
                    check("resp_grant", grant, oh(e.master));
                    check("resp_s_adr", s_adr, e.adr);
                    check("resp_s_we", s_we, e.we);
                    check("resp_s_dat_w", s_dat_w, e.dat);
                    check("resp_s_sel", s_sel, e.sel);
                    check("resp_dat_r", m_dat_r, slave_rdata(e.adr));
                end
            end
        end
    end

    // Grant monitor: each new grant (rising from idle) must follow the expected order.
    initial begin
        logic [N-1:0] prev;
        prev = '0;
        forever begin
            @(negedge clk);
            if (grant != '0 && prev == '0) begin
                if (gnt_q.size() == 0)
                    check("unexpected_grant", grant, 0);
                else
                    check("grant_order", grant, oh(gnt_q.pop_front()));
            end
            prev = grant;
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int c;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_cyc", s_cyc, 0);
        check("rst_s_stb", s_stb, 0);
        check("rst_s_adr", s_adr, 0);
        check("rst_grant", grant, 0);
        check("rst_resp", {m_err, m_rty, m_ack}, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single master, ACK two cycles after STB; directed latency checks.
        slave_lat = 2;
        @(posedge clk); #1;
        set_req(0, 12'h010);
        push_exp(0, K_ACK, 12'h010);
        gnt_q.push_back(0);
        @(negedge clk); check("t1_arb_latency_s_cyc", s_cyc, 0);
        @(negedge clk); check("t1_s_cyc", s_cyc, 1); check("t1_grant", grant, 3'b001);
        @(negedge clk); check("t1_no_early_ack", m_ack, 0);
        @(negedge clk); check("t1_ack", m_ack, 3'b001);
        @(posedge clk); #1 clr_req(0);
        @(negedge clk); check("t1_idle_grant", grant, 0); check("t1_idle_s_cyc", s_cyc, 0);
        drain("t1");

        // RTY passes through to the owner (ptr now 1).
        slave_lat = 0;
        slave_rty = 1'b1;
        push_exp(1, K_RTY, 12'h020);
        gnt_q.push_back(1);
        run_master(1, 1, 12'h020);
        slave_rty = 1'b0;
        drain("rty");

        // ptr = 2, m0 and m2 request together: m2 first, then wrap to m0.
        slave_lat = 1;
        gnt_q.push_back(2); gnt_q.push_back(0);
        push_exp(2, K_ACK, 12'h300);
        push_exp(0, K_ACK, 12'h030);
        fork
            run_master(0, 1, 12'h030);
            run_master(2, 1, 12'h300);
        join
        drain("wrap");

        // From reset, m0 and m1 keep re-requesting: grants alternate 0,1,0,1,0,1.
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            gnt_q.push_back(0); gnt_q.push_back(1);
            push_exp(0, K_ACK, 12'h100 + AW'(k));
            push_exp(1, K_ACK, 12'h200 + AW'(k));
        end
        fork
            run_master(0, 3, 12'h100);
            run_master(1, 3, 12'h200);
        join
        drain("alt");

        // ptr = 2; one m2 transfer brings it back to 0.
        gnt_q.push_back(2);
        push_exp(2, K_ACK, 12'h2F0);
        run_master(2, 1, 12'h2F0);
        drain("m2");

        // m1 drops CYC one cycle into BUSY; a late slave ACK must not reach anyone.
        slave_auto = 1'b0;
        gnt_q.push_back(1);
        @(posedge clk); #1 set_req(1, 12'h040);
        @(posedge clk); #1 clr_req(1);
        #1 s_ack = 1'b1;
        @(negedge clk); check("abort_no_ack", m_ack, 0); check("abort_s_cyc", s_cyc, 0);
        @(negedge clk); check("abort_idle_grant", grant, 0); check("abort_no_ack2", m_ack, 0);
        @(posedge clk); #2 s_ack = 1'b0;
        slave_auto = 1'b1;
        // Abort advanced ptr to 2: with m1 and m2 pending, m2 wins.
        gnt_q.push_back(2); gnt_q.push_back(1);
        push_exp(2, K_ACK, 12'h052);
        push_exp(1, K_ACK, 12'h051);
        fork
            run_master(1, 1, 12'h051);
            run_master(2, 1, 12'h052);
        join
        drain("abort");

        // ptr = 2; reset asserted in the same cycle as the slave ACK.
        slave_lat = 2;
        gnt_q.push_back(0);
        @(posedge clk); #1 set_req(0, 12'h060);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk); check("rst_ack_s_ack_seen", s_ack, 1); check("rst_beats_ack", m_ack, 0);
        @(posedge clk); #1 rst_n = 1'b1; clr_req(0);
        @(negedge clk); check("rst_mid_s_cyc", s_cyc, 0); check("rst_mid_grant", grant, 0);
        // ptr must be 0 again: m0 beats m2.
        slave_lat = 1;
        gnt_q.push_back(0); gnt_q.push_back(2);
        push_exp(0, K_ACK, 12'h070);
        push_exp(2, K_ACK, 12'h072);
        fork
            run_master(0, 1, 12'h070);
            run_master(2, 1, 12'h072);
        join
        drain("rst_ptr");

`ifdef WB_ARB_TIMEOUT_EN
        // Silent slave: ERR on the 8th BUSY cycle, then back to IDLE.
        slave_silent = 1'b1;
        gnt_q.push_back(0);
        push_exp(0, K_ERR, 12'h080);
        @(posedge clk); #1 set_req(0, 12'h080);
        @(negedge clk);
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!m_err[0] && c < 40);
        check("err_cycle", c, 8);
        @(posedge clk); #1 clr_req(0);
        slave_silent = 1'b0;
        @(negedge clk); check("err_idle_grant", grant, 0);
        drain("wd");
`else
        c = 0;
`endif

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
